gcla_result_bcd: RTL and testbench

- Sequential consumer of the adder/subtractor result bus (8-bit magnitude, sign, overflow).
- Converts the magnitude to packed BCD digits using iterative shift-add-3 (double-dabble), one bit per clock.
- Presents the digits plus sign/error flags to the display stage through a valid/ready handshake.
- Sits between the GCLA add/sub datapath and the calculator's digit display.

---
 rtl/gcla_result_bcd.sv | 148 ++++++++++++++
 tb/tb_gcla_result_bcd.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcla_result_bcd.sv
// rtl/gcla_result_bcd.sv - GCLA result to BCD converter (double-dabble, 1 bit/clk); SEVEN_SEG_EN adds seg decode
module gcla_result_bcd #(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_mag,
    input  logic                  in_neg,
    input  logic                  in_ovr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              r_state, w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [N-1:0]        r_shift;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_sign, r_err, r_in_ready, r_out_valid;
    logic [4*DIGITS-1:0] w_adj, w_bcd_step;
    logic                w_accept, w_last, w_handshake;

    assign w_accept    = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_last      = (r_state == S_SHIFT) && (r_cnt == CW'(N - 1));
    assign w_handshake = (r_state == S_DONE) && r_out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = in_ovr ? S_DONE : S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  if (w_handshake) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every digit >= 5, then the whole {bcd, shift} moves left one bit.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
        w_bcd_step = {w_adj[4*DIGITS-2:0], r_shift[N-1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_sign      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == S_IDLE);
            // Overflow results arrive in DONE with out_valid low; it rises one edge later.
            r_out_valid <= w_last || ((r_state == S_DONE) && !w_handshake);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_mag;
                        r_bcd   <= '0;
                        r_sign  <= in_neg;
                        r_err   <= in_ovr;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_step;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && (r_state == S_SHIFT)) begin
            for (int d = 0; d < DIGITS; d++)
                assert (r_bcd[4*d +: 4] <= 4'd9);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign sign      = r_sign;
    assign err       = r_err;

`ifdef SEVEN_SEG_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [7*DIGITS-1:0] r_seg, w_seg_next;
    logic [4*DIGITS-1:0] w_seg_src;
    logic                w_seg_load;

    // Load on the same edge out_valid rises: last shift, or first DONE cycle after overflow.
    assign w_seg_load = w_last || ((r_state == S_DONE) && !r_out_valid);
    assign w_seg_src  = (r_state == S_SHIFT) ? w_bcd_step : r_bcd;

    always_comb begin
        w_seg_next = '1;
        for (int d = 0; d < DIGITS; d++)
            w_seg_next[7*d +: 7] = r_err ? 7'b0000110 : seg_decode(w_seg_src[4*d +: 4]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_seg <= '1;
        else if (w_seg_load)
            r_seg <= w_seg_next;
    end

    assign seg = r_seg;
`else
    assign seg = '1;
`endif

endmodule

// File: tb/tb_gcla_result_bcd.sv
// tb/tb_gcla_result_bcd.sv - scoreboard bench for gcla_result_bcd
module tb_gcla_result_bcd;

    localparam int N      = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_mag;
    logic                in_neg;
    logic                in_ovr;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
    logic                err;
    logic [7*DIGITS-1:0] seg;

    always #5 clk = ~clk;

    gcla_result_bcd #(.N(N), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_neg    (in_neg),
        .in_ovr    (in_ovr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .sign      (sign),
        .err       (err),
        .seg       (seg)
    );

    typedef struct packed {
        logic [11:0] bcd;
        logic        sign;
        logic        err;
        logic [20:0] seg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       seg_of = 7'b1000000;
            1:       seg_of = 7'b1111001;
            2:       seg_of = 7'b0100100;
            3:       seg_of = 7'b0110000;
            4:       seg_of = 7'b0011001;
            5:       seg_of = 7'b0010010;
            6:       seg_of = 7'b0000010;
            7:       seg_of = 7'b1111000;
            8:       seg_of = 7'b0000000;
            default: seg_of = 7'b0010000;
        endcase
    endfunction

    function automatic exp_t model(input int mag, input bit neg, input bit ovr);
        exp_t e;
        e.sign = neg;
        e.err  = ovr;
        if (ovr) e.bcd = 12'h000;
        else     e.bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
`ifdef SEVEN_SEG_EN
        if (ovr) e.seg = {3{7'b0000110}};
        else     e.seg = {seg_of(mag / 100), seg_of((mag / 10) % 10), seg_of(mag % 10)};
`else
        e.seg = '1;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("bcd",  32'(bcd),  32'(mon_e.bcd));
                check("sign", 32'(sign), 32'(mon_e.sign));
                check("err",  32'(err),  32'(mon_e.err));
                check("seg",  32'(seg),  32'(mon_e.seg));
            end
        end
    end

    task automatic accept(input int mag, input bit neg, input bit ovr);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_mag   = N'(mag);
        in_neg   = neg;
        in_ovr   = ovr;
        in_valid = 1'b1;
        sb_q.push_back(model(mag, neg, ovr));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
            check("in_ready_busy", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(k), 32'(exp_lat));
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_out_valid_drop", 32'(out_valid), 32'd0);
        check("hs_in_ready_rise",  32'(in_ready),  32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] held_bcd;
        int          m;
        bit          ng, ov;

        in_valid  = 1'b0;
        in_mag    = '0;
        in_neg    = 1'b0;
        in_ovr    = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        #20;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_bcd",       32'(bcd),       32'd0);
        check("rst_sign",      32'(sign),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_seg",       32'(seg),       32'h1FFFFF);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        accept(255, 1'b0, 1'b0);
        wait_valid(8);
        finish_hs();

        // Output handshake and a waiting input in the same DONE cycle: no back-to-back accept.
        accept(0, 1'b0, 1'b0);
        wait_valid(8);
        in_mag    = 8'd100;
        in_neg    = 1'b1;
        in_ovr    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb_q.push_back(model(100, 1'b1, 1'b0));
        @(posedge clk); #1;
        check("no_b2b_out_valid", 32'(out_valid), 32'd0);
        check("no_b2b_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(8);
        finish_hs();

        accept(0, 1'b1, 1'b0);
        wait_valid(8);
        finish_hs();

        accept(37, 1'b0, 1'b1);
        wait_valid(1);
        finish_hs();

        accept(123, 1'b1, 1'b0);
        wait_valid(8);
        held_bcd = bcd;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_mag   = 8'd77;
            @(posedge clk); #1;
            check("bp_bcd",       32'(bcd),       32'(held_bcd));
            check("bp_sign",      32'(sign),      32'd1);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        finish_hs();

        accept(200, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd",       32'(bcd),       32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_seg",       32'(seg),       32'h1FFFFF);
        void'(sb_q.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready_back", 32'(in_ready), 32'd1);
        accept(59, 1'b0, 1'b0);
        wait_valid(8);
        finish_hs();

        accept(48, 1'b0, 1'b0);
        wait_valid(8);
        finish_hs();

        for (int i = 0; i < 8; i++) begin
            m  = int'($urandom_range(0, 255));
            ng = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 3) == 0);
            accept(m, ng, ov);
            wait_valid(ov ? 1 : 8);
            finish_hs();
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
